// File: rtl/dc2_expun_queue.sv
// dc2_expun_queue: 8-entry dirty-victim writeback queue with duplicate merge and optional snoop (DC2_EXPUN_SNOOP_EN)
module dc2_expun_queue #(
  parameter int AFULL_LVL = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exp_en,
  input  logic        exp_odd,
  input  logic [35:0] exp_addrE,
  input  logic [35:0] exp_addrO,
  input  logic        exp_dirty,
  output logic        wb_valid,
  output logic [36:0] wb_addr,
  input  logic        wb_ready,
  output logic        exp_afull,
  output logic [3:0]  exp_count,
  output logic        exp_ovf,
  input  logic [36:0] snp_addr,
  output logic        snp_hit
);
  logic [36:0] mem [8];
  logic [2:0]  rd_ptr, wr_ptr;
  logic [3:0]  count;
  logic        ovf;
  logic [36:0] din;
  logic        push_cand, pop, full, dup, accept, ovf_set;
  // push/pop qualification; a repeat of the newest entry is merged unless that entry is leaving now
  always_comb begin
    din       = {exp_odd ? exp_addrO : exp_addrE, exp_odd};
    push_cand = exp_en & exp_dirty;
    pop       = (count != 4'd0) & wb_ready;
    full      = count == 4'd8;
    dup       = push_cand & (count != 4'd0) & (din == mem[wr_ptr - 3'd1]) & ~((count == 4'd1) & pop);
    accept    = push_cand & ~dup & (~full | pop);
    ovf_set   = push_cand & ~dup & full & ~pop;
  end
  // pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 3'd0;
      wr_ptr <= 3'd0;
      count  <= 4'd0;
      ovf    <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 3'd1;
      if (pop) rd_ptr <= rd_ptr + 3'd1;
      count <= count + {3'd0, accept} - {3'd0, pop};
      if (ovf_set) ovf <= 1'b1;
    end
  end
  // entry storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= din;
  end
  assign wb_valid  = count != 4'd0;
  assign wb_addr   = mem[rd_ptr];
  assign exp_afull = count >= 4'(AFULL_LVL);
  assign exp_count = count;
  assign exp_ovf   = ovf;
`ifdef DC2_EXPUN_SNOOP_EN
  logic [7:0] hit;
  // per-entry compare, qualified by the entry lying inside the occupied window
  always_comb begin
    hit = '0;
    for (int i = 0; i < 8; i++)
      hit[i] = ({1'b0, 3'(i) - rd_ptr} < count) && (mem[i] == snp_addr);
  end
  assign snp_hit = |hit;
`else
  logic snp_unused;
  assign snp_unused = ^snp_addr;
  assign snp_hit    = 1'b0;
`endif
endmodule

// File: tb/tb_dc2_expun_queue.sv
// tb_dc2_expun_queue: directed and random checks of dc2_expun_queue against a queue-based model
module tb_dc2_expun_queue;
  logic        clk = 0;
  logic        rst, exp_en, exp_odd, exp_dirty, wb_ready;
  logic [35:0] exp_addrE, exp_addrO;
  logic [36:0] snp_addr, wb_addr;
  logic        wb_valid, exp_afull, exp_ovf, snp_hit;
  logic [3:0]  exp_count;
  int total = 0, bad = 0;
  logic [36:0] q[$];
  logic        m_ovf = 0;

  dc2_expun_queue #(.AFULL_LVL(6)) dut (
    .clk(clk), .rst(rst), .exp_en(exp_en), .exp_odd(exp_odd),
    .exp_addrE(exp_addrE), .exp_addrO(exp_addrO), .exp_dirty(exp_dirty),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_ready(wb_ready),
    .exp_afull(exp_afull), .exp_count(exp_count), .exp_ovf(exp_ovf),
    .snp_addr(snp_addr), .snp_hit(snp_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic snoop_model(input logic [36:0] a);
    logic h = 0;
`ifdef DC2_EXPUN_SNOOP_EN
    foreach (q[i]) if (q[i] == a) h = 1;
`endif
    return h;
  endfunction

  // drive one cycle, compare outputs to model before the edge, then advance the model
  task automatic cyc(input logic en, input logic odd, input logic [35:0] ae, input logic [35:0] ao,
                     input logic dirty, input logic ready, input logic r, input logic [36:0] snp);
    logic [36:0] d;
    logic push, popm, dupm;
    exp_en = en; exp_odd = odd; exp_addrE = ae; exp_addrO = ao;
    exp_dirty = dirty; wb_ready = ready; rst = r; snp_addr = snp;
    @(negedge clk);
    chk("wb_valid", 64'(wb_valid), 64'(q.size() != 0));
    if (q.size() != 0) chk("wb_addr", 64'(wb_addr), 64'(q[0]));
    chk("exp_count", 64'(exp_count), 64'(q.size()));
    chk("exp_afull", 64'(exp_afull), 64'(q.size() >= 6));
    chk("exp_ovf", 64'(exp_ovf), 64'(m_ovf));
    chk("snp_hit", 64'(snp_hit), 64'(snoop_model(snp)));
    if (r) begin
      q.delete();
      m_ovf = 0;
    end else begin
      d    = {odd ? ao : ae, odd};
      push = en & dirty;
      popm = (q.size() != 0) & ready;
      dupm = push && q.size() >= 1 && d == q[$] && !(q.size() == 1 && popm);
      if (push && !dupm && q.size() == 8 && !popm) m_ovf = 1;
      if (popm) void'(q.pop_front());
      if (push && !dupm && q.size() < 8) q.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ready);
    cyc(0, 0, 0, 0, 0, ready, 0, 0);
  endtask

  task automatic do_rst();
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    do_rst();
    do_rst();
    chk("rst_count", 64'(exp_count), 0);
    chk("rst_valid", 64'(wb_valid), 0);
    chk("rst_snp", 64'(snp_hit), 0);
    // single odd push becomes visible next cycle
    cyc(1, 1, 36'h0, 36'h123456789, 1, 0, 0, 0);
    chk("odd_addr", 64'(wb_addr), 64'(37'h02468ACF13));
    chk("odd_count", 64'(exp_count), 1);
    chk("odd_valid", 64'(wb_valid), 1);
    // fill to 8, afull at 6, overflow on 9th
    do_rst();
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 36'(i + 1), 0, 1, 0, 0, 0);
      chk("fill_afull", 64'(exp_afull), 64'(i + 1 >= 6));
    end
    chk("fill_ovf0", 64'(exp_ovf), 0);
    cyc(1, 0, 36'h99, 0, 1, 0, 0, 0);
    chk("ovf_set", 64'(exp_ovf), 1);
    chk("ovf_count", 64'(exp_count), 8);
    // pop down to 5 then reset mid-stream
    for (int i = 0; i < 3; i++) idle(1);
    chk("five_count", 64'(exp_count), 5);
    do_rst();
    chk("mid_rst_valid", 64'(wb_valid), 0);
    chk("mid_rst_count", 64'(exp_count), 0);
    chk("mid_rst_ovf", 64'(exp_ovf), 0);
    // push with pop at full
    for (int i = 0; i < 8; i++) cyc(1, 0, 36'(i + 16), 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 36'h777, 1, 1, 0, 0);
    chk("full_pp_count", 64'(exp_count), 8);
    chk("full_pp_ovf", 64'(exp_ovf), 0);
    chk("full_pp_head", 64'(wb_addr), 64'({36'd17, 1'b0}));
    // duplicate merge, then exception when the lone entry pops
    do_rst();
    cyc(1, 0, 36'h55, 0, 1, 0, 0, 0);
    cyc(1, 0, 36'h55, 0, 1, 0, 0, 0);
    chk("dup_count", 64'(exp_count), 1);
    cyc(1, 0, 36'h55, 0, 1, 1, 0, 0);
    chk("dup_pop_count", 64'(exp_count), 1);
    chk("dup_pop_valid", 64'(wb_valid), 1);
    // clean victim ignored
    cyc(1, 1, 0, 36'hABC, 0, 0, 0, 0);
    chk("clean_count", 64'(exp_count), 1);
    // snoop
    do_rst();
    cyc(1, 1, 0, 36'h80, 1, 0, 0, 0);
`ifdef DC2_EXPUN_SNOOP_EN
    snp_addr = 37'h0000000101; #1;
    chk("snp_match", 64'(snp_hit), 1);
`else
    snp_addr = 37'h0000000101; #1;
    chk("snp_off", 64'(snp_hit), 0);
`endif
    snp_addr = 37'h0000000100; #1;
    chk("snp_miss", 64'(snp_hit), 0);
    // randomized traffic over a small address pool to provoke merges, fulls and snoop hits
    do_rst();
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 9) < 7, 1'($urandom), 36'($urandom_range(0, 3)), 36'($urandom_range(0, 3)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 4, $urandom_range(0, 79) == 0,
          {36'($urandom_range(0, 3)), 1'($urandom)});
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
